// File: rtl/pattern_shifter_pkg.sv
// Shared types and constants for the pattern shifter: mode encoding,
// direction constants and the reset-pattern helper.
package pattern_shifter_pkg;

  typedef enum logic [1:0] {
    ROTATE = 2'b00,
    BOUNCE = 2'b01,
    FILL   = 2'b10,
    HOLD   = 2'b11
  } mode_t;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Widest register the reset-pattern helper can describe.
  localparam int MAX_WIDTH = 256;

  function automatic logic [MAX_WIDTH-1:0] msb_only(input int width);
    logic [MAX_WIDTH-1:0] one;
    one = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    return one << (width - 1);
  endfunction

endpackage

// File: rtl/pattern_shifter_prescaler.sv
// Step prescaler: emits a one-cycle tick every PRESCALE enabled clocks.
// The count freezes while enable is low.
module step_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;

  assign tick = enable && (count_reg == LAST);

  always_comb begin
    count_next = count_reg;
    if (enable) begin
      count_next = tick ? '0 : count_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/pattern_shifter.sv
// Pattern shift register with prescaled stepping, edge-detected direction
// toggle, parallel load and ROTATE/BOUNCE/FILL/HOLD modes.
// Define PATTERN_SHIFTER_BOUNCE_EN to enable BOUNCE; otherwise mode 01 rotates.
module pattern_shifter
  import pattern_shifter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             toggle_dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] register_value,
  output logic             dir,
  output logic             step,
  output logic             wrap
);

  localparam logic [MAX_WIDTH-1:0] RESET_FULL    = msb_only(WIDTH);
  localparam logic [WIDTH-1:0]     RESET_PATTERN = RESET_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] value_reg, value_next;
  logic             dir_reg, dir_next;
  logic             step_reg, step_next;
  logic             wrap_reg, wrap_next;
  logic             t_q_reg;
  logic             tick;
  logic             presc_reset;
  logic             toggle_edge;
  logic             end_bit;
  mode_t            mode_sel;

  logic [WIDTH-1:0] rot_right, rot_left, rot_value;
  logic [WIDTH-1:0] fill_right, fill_left;

  // A load restarts the step period, so it also clears the prescaler.
  assign presc_reset = reset & ~load;

  step_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (presc_reset),
    .enable (enable),
    .tick   (tick)
  );

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign rot_right[gi] = value_reg[(gi + 1) % WIDTH];
      assign rot_left[gi]  = value_reg[(gi + WIDTH - 1) % WIDTH];
    end
  endgenerate

  assign fill_right  = {1'b1, value_reg[WIDTH-1:1]};
  assign fill_left   = {value_reg[WIDTH-2:0], 1'b1};
  assign mode_sel    = mode_t'(mode);
  assign toggle_edge = toggle_dir & ~t_q_reg;
  // Bit at the end we are travelling toward: the one that leaves on rotate.
  assign end_bit     = (dir_reg == DIR_LEFT) ? value_reg[WIDTH-1] : value_reg[0];
  assign rot_value   = (dir_reg == DIR_LEFT) ? rot_left : rot_right;

`ifdef PATTERN_SHIFTER_BOUNCE_EN
  logic [WIDTH-1:0] shr, shl;
  assign shr = value_reg >> 1;
  assign shl = value_reg << 1;
`endif

  always_comb begin
    value_next = value_reg;
    dir_next   = dir_reg ^ toggle_edge;
    step_next  = 1'b0;
    wrap_next  = 1'b0;
    if (load) begin
      value_next = load_value;
    end else if (tick) begin
      case (mode_sel)
        ROTATE: begin
          value_next = rot_value;
          step_next  = 1'b1;
          wrap_next  = end_bit;
        end
        BOUNCE: begin
          step_next = 1'b1;
`ifdef PATTERN_SHIFTER_BOUNCE_EN
          if (end_bit) begin
            // Reversal first, then any toggle edge on top of it.
            dir_next   = ~dir_reg ^ toggle_edge;
            value_next = (dir_reg == DIR_LEFT) ? shr : shl;
            wrap_next  = 1'b1;
          end else begin
            value_next = (dir_reg == DIR_LEFT) ? shl : shr;
          end
`else
          value_next = rot_value;
          wrap_next  = end_bit;
`endif
        end
        FILL: begin
          step_next = 1'b1;
          if (&value_reg) begin
            value_next = '0;
            wrap_next  = 1'b1;
          end else begin
            value_next = (dir_reg == DIR_LEFT) ? fill_left : fill_right;
          end
        end
        HOLD: begin
          value_next = value_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value_reg <= RESET_PATTERN;
      dir_reg   <= DIR_RIGHT;
      step_reg  <= 1'b0;
      wrap_reg  <= 1'b0;
      t_q_reg   <= 1'b0;
    end else begin
      value_reg <= value_next;
      dir_reg   <= dir_next;
      step_reg  <= step_next;
      wrap_reg  <= wrap_next;
      t_q_reg   <= toggle_dir;
    end
  end

  assign register_value = value_reg;
  assign dir            = dir_reg;
  assign step           = step_reg;
  assign wrap           = wrap_reg;

endmodule

// File: tb/tb_pattern_shifter.sv
// Directed bench for pattern_shifter: a vector table on a WIDTH=4/PRESCALE=1
// instance plus hand-written prescaler and toggle sequences on PRESCALE=3.
module tb_pattern_shifter;
  import pattern_shifter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=4, PRESCALE=1
  logic       a_reset = 1'b0, a_en = 1'b0, a_tog = 1'b0, a_load = 1'b0;
  logic [1:0] a_mode = 2'b00;
  logic [3:0] a_ldv = 4'b0000;
  logic [3:0] a_val;
  logic       a_dir, a_step, a_wrap;

  // Instance B: WIDTH=4, PRESCALE=3
  logic       b_reset = 1'b0, b_en = 1'b0, b_tog = 1'b0, b_load = 1'b0;
  logic [1:0] b_mode = 2'b00;
  logic [3:0] b_ldv = 4'b0000;
  logic [3:0] b_val;
  logic       b_dir, b_step, b_wrap;

  pattern_shifter #(.WIDTH(4), .PRESCALE(1)) u_a (
    .clk(clk), .reset(a_reset), .enable(a_en), .toggle_dir(a_tog),
    .mode(a_mode), .load(a_load), .load_value(a_ldv),
    .register_value(a_val), .dir(a_dir), .step(a_step), .wrap(a_wrap)
  );

  pattern_shifter #(.WIDTH(4), .PRESCALE(3)) u_b (
    .clk(clk), .reset(b_reset), .enable(b_en), .toggle_dir(b_tog),
    .mode(b_mode), .load(b_load), .load_value(b_ldv),
    .register_value(b_val), .dir(b_dir), .step(b_step), .wrap(b_wrap)
  );

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       tog;
    logic [1:0] mode;
    logic       ld;
    logic [3:0] ld_val;
    logic [3:0] exp_val;
    logic       exp_dir;
    logic       exp_step;
    logic       exp_wrap;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic t, input logic [1:0] m,
                     input logic l, input logic [3:0] lv, input logic [3:0] v,
                     input logic d, input logic s, input logic w);
    vec_t x;
    x = '{r, e, t, m, l, lv, v, d, s, w};
    vq.push_back(x);
  endtask

  localparam logic [1:0] MR = 2'b00, MB = 2'b01, MF = 2'b10, MH = 2'b11;

  logic [3:0] b_exp_vals [4];
  int         b_steps;
  logic       b_exp_step;

  initial begin
    // rst en tog mode ld ldv | val dir step wrap
    add(0, 0, 0, MR, 0, 4'b0000, 4'b1000, 0, 0, 0);
    add(0, 1, 0, MR, 1, 4'b0101, 4'b1000, 0, 0, 0);  // reset beats load+tick
    add(1, 1, 0, MR, 0, 4'b0000, 4'b0100, 0, 1, 0);
    add(1, 1, 0, MR, 0, 4'b0000, 4'b0010, 0, 1, 0);
    add(1, 1, 0, MR, 0, 4'b0000, 4'b0001, 0, 1, 0);
    add(1, 1, 0, MR, 0, 4'b0000, 4'b1000, 0, 1, 1);
    add(1, 1, 0, MR, 1, 4'b0001, 4'b0001, 0, 0, 0);  // load beats tick
`ifdef PATTERN_SHIFTER_BOUNCE_EN
    add(1, 1, 0, MB, 0, 4'b0000, 4'b0010, 1, 1, 1);
    add(1, 1, 0, MB, 0, 4'b0000, 4'b0100, 1, 1, 0);
    add(1, 1, 0, MB, 0, 4'b0000, 4'b1000, 1, 1, 0);
    add(1, 1, 0, MB, 0, 4'b0000, 4'b0100, 0, 1, 1);
`else
    add(1, 1, 0, MB, 0, 4'b0000, 4'b1000, 0, 1, 1);
    add(1, 1, 0, MB, 0, 4'b0000, 4'b0100, 0, 1, 0);
    add(1, 1, 0, MB, 0, 4'b0000, 4'b0010, 0, 1, 0);
    add(1, 1, 0, MB, 0, 4'b0000, 4'b0001, 0, 1, 0);
`endif
    add(1, 1, 0, MF, 1, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 1, 0, MF, 0, 4'b0000, 4'b1000, 0, 1, 0);
    add(1, 1, 0, MF, 0, 4'b0000, 4'b1100, 0, 1, 0);
    add(1, 1, 0, MF, 0, 4'b0000, 4'b1110, 0, 1, 0);
    add(1, 1, 0, MF, 0, 4'b0000, 4'b1111, 0, 1, 0);
    add(1, 1, 0, MF, 0, 4'b0000, 4'b0000, 0, 1, 1);
    add(1, 0, 1, MF, 0, 4'b0000, 4'b0000, 1, 0, 0);  // toggle while disabled
    add(1, 1, 1, MF, 0, 4'b0000, 4'b0001, 1, 1, 0);  // held level: no 2nd toggle
    add(1, 1, 0, MF, 0, 4'b0000, 4'b0011, 1, 1, 0);
    add(1, 1, 0, MF, 0, 4'b0000, 4'b0111, 1, 1, 0);
    add(1, 1, 0, MF, 0, 4'b0000, 4'b1111, 1, 1, 0);
    add(1, 1, 0, MF, 0, 4'b0000, 4'b0000, 1, 1, 1);
    add(1, 1, 0, MF, 1, 4'b0110, 4'b0110, 1, 0, 0);
    add(0, 1, 1, MF, 1, 4'b0101, 4'b1000, 0, 0, 0);  // reset mid-operation
    add(1, 1, 0, MH, 0, 4'b0000, 4'b1000, 0, 0, 0);
    add(1, 1, 1, MR, 0, 4'b0000, 4'b0100, 1, 1, 0);  // shift uses pre-toggle dir
    add(1, 1, 1, MR, 0, 4'b0000, 4'b1000, 1, 1, 0);
    add(1, 1, 0, MR, 0, 4'b0000, 4'b0001, 1, 1, 1);
    add(1, 1, 0, MB, 0, 4'b0000, 4'b0010, 1, 1, 0);
    add(1, 1, 0, MB, 1, 4'b1000, 4'b1000, 1, 0, 0);
`ifdef PATTERN_SHIFTER_BOUNCE_EN
    add(1, 1, 1, MB, 0, 4'b0000, 4'b0100, 1, 1, 1);  // reversal + toggle cancel
    add(1, 1, 0, MH, 0, 4'b0000, 4'b0100, 1, 0, 0);
`else
    add(1, 1, 1, MB, 0, 4'b0000, 4'b0001, 0, 1, 1);
    add(1, 1, 0, MH, 0, 4'b0000, 4'b0001, 0, 0, 0);
`endif

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      a_reset = vq[i].rst_n;
      a_en    = vq[i].en;
      a_tog   = vq[i].tog;
      a_mode  = vq[i].mode;
      a_load  = vq[i].ld;
      a_ldv   = vq[i].ld_val;
      @(posedge clk); #1;
      $display("vec %0d: val=%b dir=%b step=%b wrap=%b", i, a_val, a_dir, a_step, a_wrap);
      check($sformatf("v%0d_val", i),  32'(a_val),  32'(vq[i].exp_val));
      check($sformatf("v%0d_dir", i),  32'(a_dir),  32'(vq[i].exp_dir));
      check($sformatf("v%0d_step", i), 32'(a_step), 32'(vq[i].exp_step));
      check($sformatf("v%0d_wrap", i), 32'(a_wrap), 32'(vq[i].exp_wrap));
    end

    // PRESCALE=3: steps at cycles 3 and 6; enable low at 8,9 moves the third from 9 to 11.
    b_exp_vals[0] = 4'b1000;
    b_exp_vals[1] = 4'b0100;
    b_exp_vals[2] = 4'b0010;
    b_exp_vals[3] = 4'b0001;
    b_steps = 0;
    b_mode  = MR;
    check("b_reset_val", 32'(b_val), 32'h8);
    check("b_reset_dir", 32'(b_dir), 32'h0);
    b_reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      b_en = !(c == 8 || c == 9);
      @(posedge clk); #1;
      b_exp_step = (c == 3 || c == 6 || c == 11);
      if (b_exp_step) b_steps++;
      $display("presc cycle %0d: en=%b val=%b step=%b", c, b_en, b_val, b_step);
      check($sformatf("b_c%0d_step", c), 32'(b_step), 32'(b_exp_step));
      check($sformatf("b_c%0d_val", c),  32'(b_val),  32'(b_exp_vals[b_steps]));
    end

    // toggle_dir held high for 5 cycles inverts dir exactly once
    b_en  = 1'b0;
    b_tog = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      $display("toggle cycle %0d: dir=%b", c, b_dir);
      check($sformatf("b_tog%0d_dir", c), 32'(b_dir), 32'h1);
    end
    b_tog = 1'b0;
    @(posedge clk); #1;
    $display("toggle release: dir=%b", b_dir);
    check("b_tog_release_dir", 32'(b_dir), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
